floor_request_scheduler: RTL

//  Consumes the one-cycle request pulses produced by the per-button debouncers and latches them as pending

---
 rtl/elevator_pkg.sv | 13 +
 rtl/floor_priority_finder.sv | 35 +++
 rtl/floor_request_scheduler.sv | 114 +++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared types and default sizing for the elevator floor-call scheduler.
package elevator_pkg;

    localparam int N_FLOORS_DEF = 4;
    localparam int FLOOR_W_DEF  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10
    } state_e;

endpackage

// File: rtl/floor_priority_finder.sv
// Finds the nearest set mask bit strictly above and strictly below cur_floor.
module floor_priority_finder #(
    parameter int N_FLOORS = 4,
    parameter int FLOOR_W  = 2
) (
    input  logic [N_FLOORS-1:0] mask,
    input  logic [FLOOR_W-1:0]  cur_floor,
    output logic                found_above,
    output logic [FLOOR_W-1:0]  idx_above,
    output logic                found_below,
    output logic [FLOOR_W-1:0]  idx_below
);

    always_comb begin
        found_above = 1'b0;
        idx_above   = '0;
        found_below = 1'b0;
        idx_below   = '0;
        // Descending scan: the last hit is the lowest floor above the car.
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (mask[i] && (FLOOR_W'(i) > cur_floor)) begin
                found_above = 1'b1;
                idx_above   = FLOOR_W'(i);
            end
        end
        // Ascending scan: the last hit is the highest floor below the car.
        for (int i = 0; i < N_FLOORS; i++) begin
            if (mask[i] && (FLOOR_W'(i) < cur_floor)) begin
                found_below = 1'b1;
                idx_below   = FLOOR_W'(i);
            end
        end
    end

endmodule

// File: rtl/floor_request_scheduler.sv
// Latches floor calls and runs a SCAN sweep to pick the next target floor.
//   state   | meaning
//   IDLE    | no calls away from the car; may target cur_floor if a call waits there
//   UP      | sweeping up toward the nearest call above
//   DOWN    | sweeping down toward the nearest call below
module floor_request_scheduler
    import elevator_pkg::*;
#(
    parameter int N_FLOORS = N_FLOORS_DEF,
    parameter int FLOOR_W  = FLOOR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] req_pulse,
    input  logic [FLOOR_W-1:0]  cur_floor,
    input  logic                at_floor,
    output logic [N_FLOORS-1:0] pending,
    output logic [FLOOR_W-1:0]  target_floor,
    output logic                target_valid,
    output logic                dir_up,
    output logic                dir_down
);

    state_e                state_q, state_d;
    logic [N_FLOORS-1:0]   pending_q, pending_d;
    logic [FLOOR_W-1:0]    target_q, target_d;
    logic                  valid_q, valid_d;

    logic [N_FLOORS-1:0]   cur_sel;
    logic [N_FLOORS-1:0]   serve;
    logic [N_FLOORS-1:0]   eff;
    logic                  found_above, found_below;
    logic [FLOOR_W-1:0]    idx_above, idx_below;

    // An out-of-range cur_floor matches no bit, so nothing gets served.
    always_comb begin
        for (int i = 0; i < N_FLOORS; i++) begin
            cur_sel[i] = (cur_floor == FLOOR_W'(i));
        end
    end

    assign serve     = cur_sel & {N_FLOORS{at_floor}};
    assign eff       = pending_q & ~serve;
    assign pending_d = (pending_q | req_pulse) & ~serve;

    floor_priority_finder #(
        .N_FLOORS (N_FLOORS),
        .FLOOR_W  (FLOOR_W)
    ) u_finder (
        .mask        (eff),
        .cur_floor   (cur_floor),
        .found_above (found_above),
        .idx_above   (idx_above),
        .found_below (found_below),
        .idx_below   (idx_below)
    );

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        valid_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found_above)      state_d = ST_UP;
                else if (found_below) state_d = ST_DOWN;
            end
            ST_UP: begin
                if (!found_above)     state_d = found_below ? ST_DOWN : ST_IDLE;
            end
            ST_DOWN: begin
                if (!found_below)     state_d = found_above ? ST_UP : ST_IDLE;
            end
            default:                  state_d = ST_IDLE;
        endcase
        // Targets track the state being entered so both update on the same edge.
        case (state_d)
            ST_UP: begin
                target_d = idx_above;
                valid_d  = 1'b1;
            end
            ST_DOWN: begin
                target_d = idx_below;
                valid_d  = 1'b1;
            end
            default: begin
                if (|(eff & cur_sel) && !at_floor) begin
                    target_d = cur_floor;
                    valid_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            target_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            target_q  <= target_d;
            valid_q   <= valid_d;
        end
    end

    assign pending      = pending_q;
    assign target_floor = target_q;
    assign target_valid = valid_q;
    assign dir_up       = (state_q == ST_UP);
    assign dir_down     = (state_q == ST_DOWN);

endmodule
